// File: rtl/cic_pkg.sv
// Shared CIC chain constants and sample type; the accumulator and comb
// section must agree on CIC_WIDTH.
package cic_pkg;
  localparam int CIC_WIDTH  = 28;
  localparam int CIC_RATE   = 4;
  localparam int CIC_STAGES = 3;
  localparam int CIC_DELAY  = 1;

  typedef logic [CIC_WIDTH-1:0] cic_sample_t;
endpackage

// File: rtl/cic_comb_decim_if.sv
// Sample-in / result-out bundle of the decimating comb section.
// Handshake: in_valid has no ready and is always taken; a result transfers on
// any clock edge where out_valid && out_ready; out_valid/out_data stay stable until then.
interface cic_comb_decim_if
  import cic_pkg::*;
#(
  parameter int WIDTH = CIC_WIDTH,
  parameter int CNT_W = 2
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             ovf;
  logic             ovf_clr;
  logic [CNT_W-1:0] dbg_cnt;

  modport master (
    output in_data, in_valid, out_ready, ovf_clr,
    input  out_data, out_valid, ovf, dbg_cnt
  );

  modport slave (
    input  in_data, in_valid, out_ready, ovf_clr,
    output out_data, out_valid, ovf, dbg_cnt
  );
endinterface

// File: rtl/cic_comb_stage.sv
// One comb (differentiator) stage: y = x - x delayed by DELAY valid samples,
// mod 2^WIDTH, registered together with its valid bit.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int WIDTH = CIC_WIDTH,
  parameter int DELAY = CIC_DELAY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] y_o,
  output logic             valid_o
);
  logic [DELAY-1:0][WIDTH-1:0] hist_q, hist_d;
  logic [WIDTH-1:0]            y_q, y_d;
  logic                        valid_q;

  // Wrapping subtraction is deliberate: the upstream integrator wraps too.
  always_comb begin
    hist_d = hist_q;
    y_d    = y_q;
    if (valid_i) begin
      y_d       = x_i - hist_q[DELAY-1];
      hist_d[0] = x_i;
      for (int i = 1; i < DELAY; i++) begin
        hist_d[i] = hist_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      y_q     <= y_d;
      valid_q <= valid_i;
    end
  end

  assign y_o     = y_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/cic_comb_decim.sv
// Decimating comb section: keeps every RATE-th integrated sample, runs it
// through STAGES comb stages and holds the result in a one-entry output buffer.
module cic_comb_decim
  import cic_pkg::*;
#(
  parameter int WIDTH  = CIC_WIDTH,
  parameter int RATE   = CIC_RATE,
  parameter int STAGES = CIC_STAGES,
  parameter int DELAY  = CIC_DELAY
) (
  input  logic             clk,
  input  logic             rst_n,
  cic_comb_decim_if.slave  bus
);
  localparam int CNT_W = $clog2(RATE);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic             cap_v_q, cap_v_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;

  logic [STAGES:0][WIDTH-1:0] sx;
  logic [STAGES:0]            sv;
  logic                       drop;

  // The counter only moves on valid samples, so input gaps never shift the phase.
  always_comb begin
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    cap_v_d = 1'b0;
    if (bus.in_valid) begin
      if (cnt_q == CNT_W'(RATE - 1)) begin
        cnt_d   = '0;
        cap_d   = bus.in_data;
        cap_v_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign sx[0] = cap_q;
  assign sv[0] = cap_v_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cic_comb_stage #(
      .WIDTH (WIDTH),
      .DELAY (DELAY)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .x_i     (sx[k]),
      .valid_i (sv[k]),
      .y_o     (sx[k+1]),
      .valid_o (sv[k+1])
    );
  end

  // A result arriving while the held one is unconsumed is lost; ovf records it
  // and a same-cycle clear does not hide the new drop.
  assign drop = sv[STAGES] && out_valid_q && !bus.out_ready;

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (sv[STAGES]) begin
      if (!out_valid_q || bus.out_ready) begin
        out_data_d  = sx[STAGES];
        out_valid_d = 1'b1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    ovf_d = drop ? 1'b1 : (bus.ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      cap_q       <= '0;
      cap_v_q     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      cap_v_q     <= cap_v_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ovf       = ovf_q;
  assign bus.dbg_cnt   = cnt_q;
endmodule
